// File: rtl/flash_boot_pkg.sv
// Shared types and widths for the flash-to-RAM boot copy engine.
package flash_boot_pkg;
    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_ACK,
        WR_RAM,
        DONE
    } state_t;
endpackage

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads halfword pairs through the flash driver handshake and writes packed words to RAM.
// Optional running halfword checksum when FLASH_BOOT_CHECKSUM_EN is defined; otherwise checksum reads 0.
//
// state   | meaning
// IDLE    | waiting for a start rising edge; done holds its last value
// RD_REQ  | read request raised, waiting for the driver to go busy
// RD_WAIT | driver busy; first non-busy cycle captures the halfword
// RD_ACK  | request dropped, waiting for the driver completion pulse
// WR_RAM  | packed word presented to RAM until acknowledged
// DONE    | one cycle to drop busy and raise done
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter int                 RAM_AW     = 20,
    parameter logic [21:0]        SRC_BASE   = 22'h000000,
    parameter logic [RAM_AW-1:0]  DST_BASE   = '0,
    parameter int                 WORD_COUNT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [21:0]       fl_addr,
    output logic              fl_enable_read,
    input  logic              fl_busy,
    input  logic [HW_W-1:0]   fl_data,
    input  logic              fl_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic              ram_ack,
    output logic [HW_W-1:0]   checksum
);

    // A zero-length copy still needs a one-bit counter to keep the widths legal.
    localparam int               CNT_W    = (WORD_COUNT < 1) ? 1 : $clog2(WORD_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_COUNT);

    state_t             state, state_nxt;
    logic               start_q;
    logic               start_rise;
    logic               capture;
    logic [21:0]        src;
    logic [RAM_AW-1:0]  dst;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_inc;
    logic               half;
    logic [HW_W-1:0]    lo, hi;

    assign start_rise   = start & ~start_q;
    assign capture      = (state == RD_WAIT) && !fl_busy;
    assign word_cnt_inc = word_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        fl_enable_read = 1'b0;
        ram_we         = 1'b0;
        fl_addr        = src;
        ram_addr       = dst;
        ram_wdata      = {hi, lo};
        case (state)
            IDLE: begin
                if (start_rise) state_nxt = (WORD_COUNT == 0) ? DONE : RD_REQ;
            end
            RD_REQ: begin
                fl_enable_read = 1'b1;
                if (fl_busy) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                fl_enable_read = 1'b1;
                if (!fl_busy) state_nxt = RD_ACK;
            end
            RD_ACK: begin
                if (fl_ack) state_nxt = half ? WR_RAM : RD_REQ;
            end
            WR_RAM: begin
                ram_we = 1'b1;
                if (ram_ack) state_nxt = (word_cnt_inc == CNT_LAST) ? DONE : RD_REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            src      <= '0;
            dst      <= '0;
            word_cnt <= '0;
            half     <= 1'b0;
            lo       <= '0;
            hi       <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        src      <= SRC_BASE;
                        dst      <= DST_BASE;
                        half     <= 1'b0;
                        word_cnt <= '0;
                    end
                end
                RD_WAIT: begin
                    if (capture) begin
                        if (half) hi <= fl_data;
                        else      lo <= fl_data;
                    end
                end
                RD_ACK: begin
                    if (fl_ack) begin
                        src  <= src + 22'd1;
                        half <= ~half;
                    end
                end
                WR_RAM: begin
                    if (ram_ack) begin
                        dst      <= dst + RAM_AW'(1);
                        word_cnt <= word_cnt_inc;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FLASH_BOOT_CHECKSUM_EN
    logic [HW_W-1:0] cks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            cks <= '0;
        else if (state == IDLE && start_rise)  cks <= '0;
        else if (capture)                      cks <= cks + fl_data;
    end

    assign checksum = cks;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// Randomized scoreboard bench for flash_boot_loader with a flash driver model and a RAM responder.
module tb_flash_boot_loader;

    localparam int          WC  = 2;
    localparam logic [21:0] SRC = 22'h000000;
    localparam logic [19:0] DST = 20'h00000;

    typedef struct packed {
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [21:0] fl_addr;
    logic        fl_enable_read;
    logic        fl_busy;
    logic [15:0] fl_data;
    logic        fl_ack;
    logic [19:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_ack;
    logic [15:0] checksum;

    logic        z_start;
    logic        z_busy, z_done, z_fl_enable_read, z_ram_we;
    logic [21:0] z_fl_addr;
    logic [19:0] z_ram_addr;
    logic [31:0] z_ram_wdata;
    logic [15:0] z_checksum;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] flash [0:255];
    wr_t         sb [$];
    int          fl_acks = 0, ram_acks = 0, en_cycles = 0, z_en_cycles = 0;
    int          ram_delay = -1, busy_len = -1;
    int          hold_len = 0, last_hold = 0;
    logic        prev_we = 1'b0, prev_en = 1'b0;
    logic [19:0] prev_ra;
    logic [31:0] prev_rd;
    logic [21:0] prev_fa;
    logic [21:0] drv_addr;

    always #5 clk = ~clk;

    flash_boot_loader #(.RAM_AW(20), .SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(WC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fl_addr(fl_addr), .fl_enable_read(fl_enable_read), .fl_busy(fl_busy),
        .fl_data(fl_data), .fl_ack(fl_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_ack(ram_ack), .checksum(checksum)
    );

    flash_boot_loader #(.RAM_AW(20), .SRC_BASE(SRC), .DST_BASE(DST), .WORD_COUNT(0)) dut_zero (
        .clk(clk), .rst_n(rst_n), .start(z_start), .busy(z_busy), .done(z_done),
        .fl_addr(z_fl_addr), .fl_enable_read(z_fl_enable_read), .fl_busy(1'b0),
        .fl_data(16'h0000), .fl_ack(1'b0), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata),
        .ram_we(z_ram_we), .ram_ack(1'b0), .checksum(z_checksum)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash driver: accepts a request after 0-2 cycles, stays busy, then pulses ack one cycle after data.
    initial begin
        fl_busy = 1'b0; fl_ack = 1'b0; fl_data = '0;
        forever begin
            @(negedge clk);
            if (fl_enable_read) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                drv_addr = fl_addr;
                fl_busy  = 1'b1;
                repeat (busy_len > 0 ? busy_len : int'($urandom_range(1, 4))) @(negedge clk);
                fl_data = flash[drv_addr[7:0]];
                fl_busy = 1'b0;
                @(negedge clk);
                fl_ack = 1'b1;
                fl_acks++;
                @(negedge clk);
                fl_ack = 1'b0;
            end
        end
    end

    initial begin
        ram_ack = 1'b0;
        forever begin
            @(negedge clk);
            ram_ack = 1'b0;
            if (ram_we) begin
                repeat (ram_delay >= 0 ? ram_delay : int'($urandom_range(0, 3))) @(negedge clk);
                ram_ack = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted RAM write and checks hold stability.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_we = 1'b0; prev_en = 1'b0; hold_len = 0;
                continue;
            end
            if (z_fl_enable_read) z_en_cycles++;
            if (fl_enable_read) en_cycles++;
            if (fl_enable_read && prev_en) check("fl_addr_stable", fl_addr, prev_fa);
            if (ram_we) begin
                hold_len++;
                check("no_read_during_write", fl_enable_read, 1'b0);
                if (prev_we) begin
                    check("ram_addr_stable", ram_addr, prev_ra);
                    check("ram_wdata_stable", ram_wdata, prev_rd);
                end
                if (ram_ack) begin
                    ram_acks++;
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
                    end else begin
                        e = sb.pop_front();
                        check("ram_addr", ram_addr, e.addr);
                        check("ram_wdata", ram_wdata, e.data);
                    end
                    last_hold = hold_len;
                    hold_len  = 0;
                end
            end
            prev_we = ram_we && !ram_ack;
            prev_en = fl_enable_read;
            prev_fa = fl_addr;
            prev_ra = ram_addr;
            prev_rd = ram_wdata;
        end
    end

    task automatic run_copy(input int rdly);
        logic [15:0] cks;
        wr_t         e;
        int          cyc;
        cks = '0;
        ram_delay = rdly;
        for (int i = 0; i < WC; i++) begin
            e.addr = DST + 20'(i);
            e.data = {flash[2*i+1], flash[2*i]};
            sb.push_back(e);
            cks = cks + flash[2*i] + flash[2*i+1];
        end
`ifndef FLASH_BOOT_CHECKSUM_EN
        cks = '0;
`endif
        fl_acks  = 0;
        ram_acks = 0;
        start = 1'b1;
        @(negedge clk);
        check("busy_after_start", busy, 1'b1);
        check("done_cleared", done, 1'b0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        #3;
        check("done", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("all_words_written", sb.size(), 0);
        check("fl_ack_count", fl_acks, 2 * WC);
        check("ram_ack_count", ram_acks, WC);
        check("checksum", checksum, cks);
        sb.delete();
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; z_start = 1'b0;
        for (int i = 0; i < 256; i++) flash[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fl_en", fl_enable_read, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_checksum", checksum, 16'h0000);
        check("idle_no_requests", en_cycles, 0);

        z_start = 1'b1;
        cyc = 0;
        while (!z_done && cyc < 2) begin
            @(negedge clk);
            cyc++;
        end
        check("zero_done", z_done, 1'b1);
        repeat (5) @(negedge clk);
        check("zero_done_held", z_done, 1'b1);
        check("zero_busy", z_busy, 1'b0);
        check("zero_no_read", z_en_cycles, 0);
        check("zero_ram_we", z_ram_we, 1'b0);
        check("zero_addrs", {z_fl_addr, z_ram_addr}, 42'h0);
        check("zero_wdata_cks", {z_ram_wdata, z_checksum}, 48'h0);
        z_start = 1'b0;

        flash[0] = 16'h1111; flash[1] = 16'h2222; flash[2] = 16'h3333; flash[3] = 16'h4444;
        run_copy(-1);

        run_copy(7);
        check("ram_we_held_7", last_hold >= 8, 1'b1);

        flash[0] = 16'hFFFF; flash[1] = 16'h0002; flash[2] = 16'h0000; flash[3] = 16'h0000;
        run_copy(0);
`ifdef FLASH_BOOT_CHECKSUM_EN
        check("checksum_wrap", checksum, 16'h0001);
`else
        check("checksum_wrap", checksum, 16'h0000);
`endif

        busy_len = 6;
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!fl_busy && cyc < 50);
        check("driver_accepted", fl_busy, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_drops_fl_en", fl_enable_read, 1'b0);
        check("reset_done_low", done, 1'b0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        cyc = 0;
        while ((fl_busy || fl_ack) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        busy_len = -1;
        check("done_low_after_reset", done, 1'b0);
        for (int i = 0; i < 4; i++) flash[i] = 16'($urandom);
        run_copy(-1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) flash[i] = 16'($urandom);
            run_copy(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
